// File: rtl/p09_pkg.sv
// Shared constants and state types for the breakout paddle controller and painter.
// Geometry lives here so both stages agree on paddle size and screen limits.
package p09_pkg;

    localparam int SCREEN_WIDTH         = 640;
    localparam int PADDLE_SEGMENT_WIDTH = 8;
    localparam int PADDLE_NUM_SEGMENTS  = 6;
    localparam int PADDLE_WIDTH         = PADDLE_SEGMENT_WIDTH * PADDLE_NUM_SEGMENTS;
    localparam int PADDLE_Y             = 440;
    localparam int V_VISIBLE            = 480;

    // Rightmost legal left-edge position of the paddle.
    localparam int X_MAX = SCREEN_WIDTH - PADDLE_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE_L = 2'd1,
        MOVE_R = 2'd2
    } paddle_state_t;

endpackage

// File: rtl/p09_sync2.sv
// Generic two-flop synchroniser for bringing an asynchronous level into the clk domain.
module p09_sync2 (
    input  logic clk,
    input  logic nRst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/p09_paddle_controller.sv
// Converts left/right buttons into the paddle's left-edge x, with acceleration and
// screen clamping; x only moves once per frame, during vertical blanking.
module p09_paddle_controller
    import p09_pkg::*;
#(
    parameter int         X_INIT       = 296,
    parameter logic [8:0] UPDATE_LINE  = 9'd480,
    parameter int         SPEED_MIN    = 1,
    parameter int         SPEED_MAX    = 8,
    parameter int         ACCEL_FRAMES = 4
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       i_btn_left,
    input  logic       i_btn_right,
    input  logic       i_recentre,
    input  logic [9:0] i_hpos,
    input  logic [8:0] i_vpos,
    output logic [9:0] o_x,
    output logic       o_moving,
    output logic       o_dir
);

    localparam int         ACC_W    = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
    localparam logic [3:0] SPD_MIN  = 4'(SPEED_MIN);
    localparam logic [3:0] SPD_MAX  = 4'(SPEED_MAX);
    localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(ACCEL_FRAMES - 1);
    localparam logic [9:0]  X_RESET = 10'(X_INIT);
    localparam logic [10:0] X_LIMIT = 11'(X_MAX);

    paddle_state_t    r_state;
    logic [3:0]       r_speed;
    logic [ACC_W-1:0] r_accCnt;
    logic [9:0]       r_x;
    logic             r_moving;
    logic             r_dir;
    logic             r_recentrePend;

    logic             w_left;
    logic             w_right;

    p09_sync2 u_syncLeft (
        .clk  (clk),
        .nRst (nRst),
        .i_d  (i_btn_left),
        .o_q  (w_left)
    );

    p09_sync2 u_syncRight (
        .clk  (clk),
        .nRst (nRst),
        .i_d  (i_btn_right),
        .o_q  (w_right)
    );

    logic             w_upd;
    logic             w_doRecentre;
    logic             w_reqLeft;
    logic             w_reqRight;
    logic             w_sameDir;
    logic             w_accWrap;
    logic [3:0]       w_accelSpeed;
    logic [3:0]       w_stepSpeed;
    logic [ACC_W-1:0] w_accNext;
    logic [10:0]      w_x11;
    logic [10:0]      w_spd11;
    logic [10:0]      w_rightSum;
    logic             w_leftClamp;
    logic             w_rightClamp;
    logic             w_clamp;
    logic [9:0]       w_leftX;
    logic [9:0]       w_rightX;
    logic [9:0]       w_newX;

    assign w_upd        = (i_hpos == 10'd0) && (i_vpos == UPDATE_LINE);
    assign w_doRecentre = r_recentrePend || i_recentre;
    assign w_reqLeft    = w_left && !w_right;
    assign w_reqRight   = w_right && !w_left;

    // Acceleration: the step uses the bumped speed on the update where the counter wraps.
    assign w_sameDir    = ((r_state == MOVE_L) && w_reqLeft) || ((r_state == MOVE_R) && w_reqRight);
    assign w_accWrap    = w_sameDir && (r_accCnt == ACC_LAST);
    assign w_accelSpeed = (r_speed >= SPD_MAX) ? SPD_MAX : r_speed + 4'd1;
    assign w_stepSpeed  = !w_sameDir ? SPD_MIN : (w_accWrap ? w_accelSpeed : r_speed);
    assign w_accNext    = (w_sameDir && !w_accWrap) ? r_accCnt + 1'b1 : '0;

    assign w_x11        = {1'b0, r_x};
    assign w_spd11      = {7'd0, w_stepSpeed};
    assign w_rightSum   = w_x11 + w_spd11;
    assign w_leftClamp  = w_x11 < w_spd11;
    assign w_rightClamp = w_rightSum > X_LIMIT;
    assign w_leftX      = w_leftClamp ? 10'd0 : r_x - {6'd0, w_stepSpeed};
    assign w_rightX     = w_rightClamp ? X_LIMIT[9:0] : w_rightSum[9:0];
    assign w_clamp      = w_reqLeft ? w_leftClamp : w_rightClamp;
    assign w_newX       = w_reqLeft ? w_leftX : w_rightX;

    // Recentre requests are latched at any time but only acted on at the frame update.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state        <= IDLE;
            r_speed        <= SPD_MIN;
            r_accCnt       <= '0;
            r_x            <= X_RESET;
            r_moving       <= 1'b0;
            r_dir          <= 1'b0;
            r_recentrePend <= 1'b0;
        end else begin
            if (i_recentre) begin
                r_recentrePend <= 1'b1;
            end
            if (w_upd) begin
                r_recentrePend <= 1'b0;
                if (w_doRecentre) begin
                    r_state  <= IDLE;
                    r_speed  <= SPD_MIN;
                    r_accCnt <= '0;
                    r_x      <= X_RESET;
                    r_moving <= 1'b0;
                end else if (!w_reqLeft && !w_reqRight) begin
                    r_state  <= IDLE;
                    r_speed  <= SPD_MIN;
                    r_accCnt <= '0;
                    r_moving <= 1'b0;
                end else begin
                    r_state  <= w_reqLeft ? MOVE_L : MOVE_R;
                    r_x      <= w_newX;
                    r_speed  <= w_clamp ? SPD_MIN : w_stepSpeed;
                    r_accCnt <= w_clamp ? '0 : w_accNext;
                    r_moving <= (w_newX != r_x);
                    if (w_newX != r_x) begin
                        r_dir <= w_reqRight;
                    end
                end
            end
        end
    end

    assign o_x      = r_x;
    assign o_moving = r_moving;
    assign o_dir    = r_dir;

endmodule

// File: tb/tb_p09_paddle_controller.sv
// Randomised scoreboard bench for the paddle controller against a frame-level reference model.
module tb_p09_paddle_controller;

    localparam int XINIT = 296;
    localparam int XMAX  = 592;

    logic       clk;
    logic       nRst;
    logic       btnLeft;
    logic       btnRight;
    logic       recentre;
    logic [9:0] hpos;
    logic [8:0] vpos;
    logic [9:0] x;
    logic       moving;
    logic       dir;

    p09_paddle_controller dut (
        .clk         (clk),
        .nRst        (nRst),
        .i_btn_left  (btnLeft),
        .i_btn_right (btnRight),
        .i_recentre  (recentre),
        .i_hpos      (hpos),
        .i_vpos      (vpos),
        .o_x         (x),
        .o_moving    (moving),
        .o_dir       (dir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] x;
        logic       moving;
        logic       dir;
    } exp_t;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: run length of same-direction updates determines speed.
    int mX;
    int mRun;
    int mLast;
    bit mMoving;
    bit mDir;
    bit mPend;

    logic [9:0] preH[5] = '{10'd5, 10'd1, 10'd0, 10'd0, 10'd639};
    logic [8:0] preV[5] = '{9'd481, 9'd480, 9'd479, 9'd0, 9'd480};

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic modelReset();
        mX = XINIT; mRun = 0; mLast = 0; mMoving = 0; mDir = 0; mPend = 0;
    endtask

    task automatic modelUpdate(input bit l, input bit r, input bit rcNow);
        int   req;
        int   spd;
        int   target;
        exp_t e;
        if (mPend || rcNow) begin
            mX = XINIT; mMoving = 0; mLast = 0; mRun = 0;
        end else begin
            req = (l && !r) ? 1 : ((r && !l) ? 2 : 0);
            if (req == 0) begin
                mLast = 0; mRun = 0; mMoving = 0;
            end else begin
                if (req == mLast) mRun++;
                else begin mRun = 1; mLast = req; end
                spd = 1 + (mRun - 1) / 4;
                if (spd > 8) spd = 8;
                target = (req == 1) ? mX - spd : mX + spd;
                if (target < 0) begin target = 0; mRun = 1; end
                else if (target > XMAX) begin target = XMAX; mRun = 1; end
                mMoving = (target != mX);
                if (mMoving) mDir = (req == 2);
                mX = target;
            end
        end
        mPend = 0;
        e.x = 10'(mX); e.moving = mMoving; e.dir = mDir;
        expQ.push_back(e);
    endtask

    // One frame: buttons settle early, recentre optionally pulsed, single update cycle.
    task automatic applyStimulus(input bit l, input bit r, input int rcAt, input bit glitch);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) begin btnLeft = l; btnRight = r; end
            hpos = preH[k];
            vpos = preV[k];
            recentre = (rcAt == k);
            if (rcAt == k) mPend = 1;
        end
        @(negedge clk);
        hpos = 10'd0; vpos = 9'd480;
        recentre = (rcAt == 5);
        modelUpdate(l, r, rcAt == 5);
        @(negedge clk);
        hpos = 10'd3; vpos = 9'd481; recentre = 1'b0;
        if (glitch) btnRight = ~btnRight;
        @(negedge clk);
        hpos = 10'd4;
        btnRight = r;
    endtask

    task automatic applyReset(input bit pulseRecentre);
        @(negedge clk);
        hpos = 10'd100; vpos = 9'd200;
        nRst = 1'b0;
        #1;
        checkOutput("resetX", 32'(x), 32'(XINIT));
        checkOutput("resetMoving", 32'(moving), 0);
        checkOutput("resetDir", 32'(dir), 0);
        modelReset();
        if (pulseRecentre) begin
            @(negedge clk) recentre = 1'b1;
            @(negedge clk) recentre = 1'b0;
        end
        @(negedge clk) nRst = 1'b1;
    endtask

    // Monitor: an update cycle is observed at the edge, compared one step later.
    initial begin
        bit   wasUpd;
        exp_t e;
        forever begin
            @(posedge clk);
            wasUpd = (nRst === 1'b1) && (hpos == 10'd0) && (vpos == 9'd480);
            #1;
            if (wasUpd) begin
                if (expQ.size() == 0) begin
                    checkOutput("scoreboardUnderflow", 1, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("updX", 32'(x), 32'(e.x));
                    checkOutput("updMoving", 32'(moving), 32'(e.moving));
                    checkOutput("updDir", 32'(dir), 32'(e.dir));
                end
            end
        end
    end

    initial begin
        bit l;
        bit r;
        int rcAt;
        nRst = 1'b0; btnLeft = 1'b0; btnRight = 1'b0; recentre = 1'b0;
        hpos = 10'd5; vpos = 9'd100;
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("initX", 32'(x), 32'(XINIT));
        checkOutput("initMoving", 32'(moving), 0);
        @(negedge clk) nRst = 1'b1;

        repeat (3) applyStimulus(0, 1, -1, 0);
        checkOutput("threeRightX", 32'(x), 299);
        checkOutput("threeRightDir", 32'(dir), 1);
        applyStimulus(0, 0, -1, 0);

        applyReset(0);
        repeat (12) applyStimulus(0, 1, -1, 0);
        checkOutput("twelveRightX", 32'(x), 320);

        applyStimulus(1, 0, -1, 0);
        applyStimulus(1, 1, -1, 0);
        repeat (10) applyStimulus(0, 1, -1, 0);
        applyStimulus(1, 0, -1, 0);

        repeat (70) applyStimulus(1, 0, -1, 0);
        checkOutput("leftClampX", 32'(x), 0);
        checkOutput("leftClampMoving", 32'(moving), 0);

        repeat (95) applyStimulus(0, 1, -1, 0);
        checkOutput("rightClampX", 32'(x), XMAX);
        applyStimulus(0, 1, 2, 0);
        checkOutput("recentreX", 32'(x), XINIT);
        checkOutput("recentreMoving", 32'(moving), 0);
        applyStimulus(0, 1, -1, 0);
        checkOutput("afterRecentreX", 32'(x), XINIT + 1);
        applyStimulus(1, 0, 5, 0);
        applyStimulus(0, 0, -1, 1);
        applyStimulus(0, 0, -1, 1);
        applyReset(1);
        applyStimulus(0, 0, -1, 0);

        l = 0; r = 0;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(3) == 0) begin
                l = 1'($urandom_range(1));
                r = 1'($urandom_range(1));
            end
            rcAt = ($urandom_range(15) == 0) ? int'($urandom_range(5)) : -1;
            if ($urandom_range(40) == 0) applyReset(1'($urandom_range(1)));
            applyStimulus(l, r, rcAt, $urandom_range(7) == 0);
        end

        repeat (3) @(negedge clk);
        checkOutput("queueDrained", 32'(expQ.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/p09_paddle_controller.md
# p09_paddle_controller

Upstream stage of the breakout paddle painter: turns the player's left/right buttons into the paddle's left-edge x coordinate (`x`), which the painter compares against `hpos`. Inputs are synchronised, movement accelerates while a button is held, and the position is clamped to the screen. `x` only changes once per frame, during vertical blanking, so the painter never sees it move mid-scan.

## Interface
- `SCREEN_WIDTH`, 640: visible pixels per line.
- `PADDLE_WIDTH`, 48: paddle width in pixels (segment width 8 × 6 segments).
- `X_INIT`, 296: reset and recentre position (centred).
- `UPDATE_LINE`, 9'd480: `vpos` value on which the per-frame update fires.
- `SPEED_MIN`, 1: pixels per frame on the first frame of movement.
- `SPEED_MAX`, 8: speed ceiling, in pixels per frame.
- `ACCEL_FRAMES`, 4: consecutive same-direction updates per speed increment.
- `clk` in 1: pixel clock.
- `nRst` in 1: reset, asynchronous, active-low.
- `btn_left` in 1: raw asynchronous button, active-high.
- `btn_right` in 1: raw asynchronous button, active-high.
- `recentre` in 1: synchronous single-cycle request from the game FSM (ball lost / new game).
- `hpos` in 10: current horizontal pixel.
- `vpos` in 9: current line.
- `x` out 10: paddle left edge, in range 0..`SCREEN_WIDTH-PADDLE_WIDTH` (592).
- `moving` out 1: last update changed `x`.
- `dir` out 1: direction of last movement (0 = left, 1 = right).

## Operation
- Buttons pass through a 2-flop synchroniser. `L`/`R` denote the synchronised levels.
- Update strobe `upd` is asserted when `hpos==0 && vpos==UPDATE_LINE`, giving exactly one cycle per frame. All state except the synchronisers and `recentre_pend` changes only on `upd`.
- `recentre` sets a sticky `recentre_pend` flag.
  - At the next `upd`: `x<=X_INIT`, state←IDLE, speed←`SPEED_MIN`, `moving<=0`, and `recentre_pend` clears.
  - Recentre takes priority over the buttons.
  - If `recentre` arrives in the same cycle as `upd`, it is applied on that `upd`.
- Requested direction at `upd`:
  - `L&!R` → left.
  - `R&!L` → right.
  - Neither pressed, or both pressed → none.
- State machine, evaluated at `upd`:
  - IDLE: left → MOVE_L, right → MOVE_R; the move is applied on this same update at speed `SPEED_MIN`.
  - MOVE_L / MOVE_R, same direction requested: increment `acc_cnt`. When `acc_cnt` reaches `ACCEL_FRAMES-1`, it wraps to 0 and speed increments, saturating at `SPEED_MAX`.
  - MOVE_L / MOVE_R, opposite direction requested: switch state, speed←`SPEED_MIN`, `acc_cnt`←0, move at `SPEED_MIN`.
  - Any state, none requested: go to IDLE, speed←`SPEED_MIN`, `acc_cnt`←0, `x` held.
- Arithmetic is done in 11 bits, so there is no wrap-around:
  - Left: `x<=(x<speed)?0:x-speed`.
  - Right: `x<=(x+speed>592)?592:x+speed`.
  - Hitting a clamp resets speed to `SPEED_MIN` and `acc_cnt` to 0; the state is unchanged.
- `moving` is 1 iff the new `x` differs from the old `x`. `dir` updates only when `moving` is 1.
- `speed` is 4 bits; `acc_cnt` is sized as clog2(`ACCEL_FRAMES`).

## Timing
- Reset values:
  - `x=X_INIT`, `moving=0`, `dir=0`.
  - State IDLE, speed `SPEED_MIN`, `acc_cnt=0`.
  - Synchronisers 0, `recentre_pend=0`.
- Button-to-`L`/`R` latency is 2 cycles. A button level is honoured only if it is present at the `upd` cycle.
- `x`, `moving` and `dir` change on the clock edge that ends the `upd` cycle. They are stable for the remainder of the frame, and always outside the visible area (`vpos` ≥ 480).
- Reset mid-frame or mid-movement: all registers take reset values immediately. The first update after release occurs at the next `upd`.
- A `recentre` pulse during reset is dropped.

## Structure
- Shared package `p09_pkg` holds `SCREEN_WIDTH`, `PADDLE_SEGMENT_WIDTH`, `PADDLE_NUM_SEGMENTS`, `PADDLE_WIDTH`, `PADDLE_Y`, `V_VISIBLE` and the state enum {IDLE, MOVE_L, MOVE_R}. The painter uses the same constants.
- One sub-module: `p09_sync2`, a generic 2-flop synchroniser with async active-low reset. It is instantiated once per button.

## Test plan
- Reset → `x=296`, `moving=0`. Hold `R` for 3 frames → `x` = 297, 298, 299 after each `upd`; `moving=1`, `dir=1`.
- Hold `R` for 12 frames → per-frame steps 1,1,1,1,2,2,2,2,3,3,3,3; final `x=296+24=320`.
- Set `x=5` (reach it via left moves), then hold `L` at speed ≥ 6 → `x=0` (clamp), speed resets. Next `upd` with `L` held → `x=0`, `moving=0`.
- Assert both buttons → `x` unchanged, state IDLE. Toggle `R`→`L` between frames at speed 3 → first left step is 1.
- Pulse `recentre` mid-frame while `R` is held at `x=500` → at next `upd`, `x=296`, `moving=0`. The following frame steps +1.
- Button pulse that starts and ends between two `upd` strobes → `x` unchanged. Assert `nRst` low mid-frame → `x=296` immediately.
